rx_lane_merger: RTL and testbench

RX_LANE_MERGER -- requirements
Module: rx_lane_merger

---
 rtl/rx_lane_merger.sv | 201 ++++++++++++++++++++
 tb/tb_rx_lane_merger.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_merger.sv
// rx_lane_merger
//   Merges NUM_RX_LANES inbound AXI-Stream lanes into one controller-bound
//   stream. Whole packets are granted round-robin; a packet whose first-beat
//   message type is not a known software/hardware message is consumed and
//   discarded instead of being forwarded.
//
// Ports
//   s_axis_aclk, s_axis_aresetn : clock, synchronous active-low reset
//   s_axis_t{valid,data,keep,last,ready} [NUM_RX_LANES] : inbound lanes
//   m_axis_t{valid,data,keep,last,ready} : merged output stream
//   m_axis_tuser : source lane of the beat currently on m_axis
//   pkt_count    : forwarded packets (wraps)
//   drop_count   : dropped packets (saturates)

module rx_lane_merger #(
    parameter int NUM_RX_LANES = 2,
    parameter int LID_W        = (NUM_RX_LANES > 2) ? $clog2(NUM_RX_LANES) : 1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              s_axis_tvalid [NUM_RX_LANES],
    input  logic [31:0]       s_axis_tdata  [NUM_RX_LANES],
    input  logic [3:0]        s_axis_tkeep  [NUM_RX_LANES],
    input  logic              s_axis_tlast  [NUM_RX_LANES],
    output logic              s_axis_tready [NUM_RX_LANES],
    output logic              m_axis_tvalid,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [LID_W-1:0]  m_axis_tuser,
    output logic [15:0]       pkt_count,
    output logic [15:0]       drop_count
);

    // Message types 1 .. NUM_SWHW_MSG_TYPES-1 are forwarded; 0 is reserved.
    localparam logic [7:0] NUM_SWHW_MSG_TYPES = 8'd3;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LID_W-1:0] grant;
    logic [LID_W-1:0] last_grant;
    logic [LID_W-1:0] pick;
    logic             found;
    logic [7:0]       pick_type;
    logic             pick_fwd;
    int               rr_idx;

    logic             sel_valid;
    logic [31:0]      sel_data;
    logic [3:0]       sel_keep;
    logic             sel_last;
    logic             out_free;
    logic             lane_hs;
    logic             pkt_done;

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign pick_fwd = (pick_type != 8'd0) && (pick_type < NUM_SWHW_MSG_TYPES);
    assign pkt_done = lane_hs && sel_last;

    // Round-robin search: candidates are visited starting one past the
    // previous grant and wrapping, so the previous owner comes last.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_type = '0;
        rr_idx    = 0;
        for (int k = 1; k <= NUM_RX_LANES; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_RX_LANES;
            for (int j = 0; j < NUM_RX_LANES; j++) begin
                if (!found && (j == rr_idx) && s_axis_tvalid[j]) begin
                    found     = 1'b1;
                    pick      = LID_W'(j);
                    pick_type = s_axis_tdata[j][7:0];
                end
            end
        end
    end

    // Mux the granted lane onto a single set of selected signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_RX_LANES; i++) begin
            if (grant == LID_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_data  = s_axis_tdata[i];
                sel_keep  = s_axis_tkeep[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // State register.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-lane ready. Only the granted lane is ever readied;
    // in FWD it is throttled by the single-entry output register.
    always_comb begin
        state_next = state;
        lane_hs    = 1'b0;
        for (int i = 0; i < NUM_RX_LANES; i++) begin
            s_axis_tready[i] = 1'b0;
        end
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = pick_fwd ? FWD : DROP;
                end
            end
            FWD: begin
                for (int i = 0; i < NUM_RX_LANES; i++) begin
                    if (grant == LID_W'(i)) begin
                        s_axis_tready[i] = out_free;
                    end
                end
                lane_hs = sel_valid && out_free;
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                for (int i = 0; i < NUM_RX_LANES; i++) begin
                    if (grant == LID_W'(i)) begin
                        s_axis_tready[i] = 1'b1;
                    end
                end
                lane_hs = sel_valid;
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant is latched when IDLE picks a lane; last_grant only moves once the
    // packet has fully completed. Reset makes lane 0 the first candidate.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            grant      <= '0;
            last_grant <= LID_W'(NUM_RX_LANES - 1);
        end else begin
            if (state == IDLE && found) begin
                grant <= pick;
            end
            if (pkt_done) begin
                last_grant <= grant;
            end
        end
    end

    // Output register: loads on a FWD handshake, otherwise empties when the
    // downstream accepts. Data is untouched while stalled.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (state == FWD && lane_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
            m_axis_tuser  <= grant;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Packet counters, updated on the tlast handshake.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else if (pkt_done) begin
            if (state == FWD) begin
                pkt_count <= pkt_count + 16'd1;
            end else if (state == DROP && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_lane_merger.sv
// tb_rx_lane_merger
//   Directed bench for rx_lane_merger with two lanes. Each lane is fed from a
//   queue of beats; output beats are collected with the cycle they were
//   accepted so ordering, content and spacing can be checked per scenario.

module tb_rx_lane_merger;

    localparam int N = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [0:0]  user;
        int          cyc;
    } obeat_t;

    logic        clk = 1'b0;
    logic        s_axis_aresetn;
    logic        s_axis_tvalid [N];
    logic [31:0] s_axis_tdata  [N];
    logic [3:0]  s_axis_tkeep  [N];
    logic        s_axis_tlast  [N];
    logic        s_axis_tready [N];
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [0:0]  m_axis_tuser;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    beat_t  q0[$];
    beat_t  q1[$];
    obeat_t out_q[$];
    int     checks   = 0;
    int     errors   = 0;
    int     cyc      = 0;
    int     hs_total = 0;

    always #5 clk = ~clk;

    rx_lane_merger #(.NUM_RX_LANES(N), .LID_W(1)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (s_axis_aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    // Payload pattern: lane marker, packet tag, beat index, and the message
    // type in the low byte of the first beat.
    function automatic logic [31:0] beat_data(input int lane, input logic [7:0] mtype,
                                              input int tag, input int b);
        return {8'hA0 + 8'(lane), 8'(tag), 8'(b), (b == 0) ? mtype : 8'h5A};
    endfunction

    // Present the head of each lane queue.
    task automatic drive_inputs();
        s_axis_tvalid[0] = (q0.size() > 0);
        s_axis_tdata[0]  = (q0.size() > 0) ? q0[0].data : 32'h0;
        s_axis_tkeep[0]  = (q0.size() > 0) ? q0[0].keep : 4'h0;
        s_axis_tlast[0]  = (q0.size() > 0) ? q0[0].last : 1'b0;
        s_axis_tvalid[1] = (q1.size() > 0);
        s_axis_tdata[1]  = (q1.size() > 0) ? q1[0].data : 32'h0;
        s_axis_tkeep[1]  = (q1.size() > 0) ? q1[0].keep : 4'h0;
        s_axis_tlast[1]  = (q1.size() > 0) ? q1[0].last : 1'b0;
    endtask

    // One clock: handshakes and output beats are sampled at the falling edge,
    // inputs are advanced just after the rising edge.
    task automatic tick();
        logic hs0;
        logic hs1;
        @(negedge clk);
        hs0 = s_axis_tvalid[0] && s_axis_tready[0];
        hs1 = s_axis_tvalid[1] && s_axis_tready[1];
        if (m_axis_tvalid && m_axis_tready)
            out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (hs0 && q0.size() > 0) q0.delete(0);
        if (hs1 && q1.size() > 0) q1.delete(0);
        hs_total += int'(hs0) + int'(hs1);
        drive_inputs();
    endtask

    task automatic push_pkt(input int lane, input logic [7:0] mtype, input int nbeats,
                            input int tag, input logic [3:0] last_keep);
        beat_t bt;
        for (int b = 0; b < nbeats; b++) begin
            bt.data = beat_data(lane, mtype, tag, b);
            bt.keep = (b == nbeats - 1) ? last_keep : 4'hF;
            bt.last = (b == nbeats - 1);
            if (lane == 0) q0.push_back(bt);
            else           q1.push_back(bt);
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        s_axis_aresetn = 1'b0;
        m_axis_tready  = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        tick();
        s_axis_aresetn = 1'b1;
        out_q.delete();
    endtask

    task automatic run_until_drained(input int budget, input string name);
        int n = 0;
        while (n < budget && !(q0.size() == 0 && q1.size() == 0 && !m_axis_tvalid)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s drain: got timeout after %0d cycles, expected drained", name, n);
        end
    endtask

    task automatic test_reset();
        s_axis_aresetn = 1'b0;
        m_axis_tready  = 1'b0;
        q0.delete();
        q1.delete();
        drive_inputs();
        tick();
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 39'h0) begin
            errors++;
            $display("[TB] FAIL reset_m_axis: got %h, expected 0",
                     {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        end
        checks++;
        if ({pkt_count, drop_count} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %h, expected 0", {pkt_count, drop_count});
        end
        checks++;
        if ({s_axis_tready[0], s_axis_tready[1]} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_tready: got %b%b, expected 00", s_axis_tready[0], s_axis_tready[1]);
        end
        s_axis_aresetn = 1'b1;
        m_axis_tready  = 1'b1;
    endtask

    task automatic test_single_lane();
        logic [39:0] got;
        logic [39:0] exp;
        apply_reset();
        push_pkt(0, 8'd1, 4, 1, 4'h3);
        run_until_drained(40, "single_lane");
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL single_lane_count: got %0d beats, expected 4", out_q.size());
        end
        for (int b = 0; b < 4 && b < out_q.size(); b++) begin
            got = {out_q[b].data, out_q[b].keep, out_q[b].last, out_q[b].user, 2'b00};
            exp = {beat_data(0, 8'd1, 1, b), (b == 3) ? 4'h3 : 4'hF, b == 3, 1'b0, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL single_lane_beat%0d: got %h, expected %h", b, got, exp);
            end
            checks++;
            if (out_q[b].cyc != out_q[0].cyc + b) begin
                errors++;
                $display("[TB] FAIL single_lane_rate%0d: got cycle %0d, expected %0d",
                         b, out_q[b].cyc, out_q[0].cyc + b);
            end
        end
        checks++;
        if (pkt_count !== 16'd1 || drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL single_lane_counters: got pkt %0d drop %0d, expected 1 0", pkt_count, drop_count);
        end
    endtask

    task automatic test_round_robin();
        int lanes [4] = '{0, 1, 0, 1};
        int tags  [4] = '{1, 1, 2, 2};
        int idx;
        int gap;
        logic [37:0] got;
        logic [37:0] exp;
        apply_reset();
        push_pkt(0, 8'd2, 3, 1, 4'hF);
        push_pkt(0, 8'd2, 3, 2, 4'hF);
        push_pkt(1, 8'd2, 3, 1, 4'hF);
        push_pkt(1, 8'd2, 3, 2, 4'hF);
        run_until_drained(80, "round_robin");
        checks++;
        if (out_q.size() != 12) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d beats, expected 12", out_q.size());
        end
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                idx = p * 3 + b;
                if (idx < out_q.size()) begin
                    got = {out_q[idx].data, out_q[idx].keep, out_q[idx].last, out_q[idx].user};
                    exp = {beat_data(lanes[p], 8'd2, tags[p], b), 4'hF, b == 2, 1'(lanes[p])};
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("[TB] FAIL rr_pkt%0d_beat%0d: got %h, expected %h", p, b, got, exp);
                    end
                    if (idx > 0) begin
                        gap = out_q[idx].cyc - out_q[idx - 1].cyc;
                        checks++;
                        if (gap != ((b == 0) ? 2 : 1)) begin
                            errors++;
                            $display("[TB] FAIL rr_spacing%0d: got %0d, expected %0d", idx, gap, (b == 0) ? 2 : 1);
                        end
                    end
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd4) begin
            errors++;
            $display("[TB] FAIL rr_pkt_count: got %0d, expected 4", pkt_count);
        end
    endtask

    task automatic test_drop();
        logic [37:0] got;
        logic [37:0] exp;
        apply_reset();
        push_pkt(1, 8'd0, 5, 1, 4'hF);
        push_pkt(1, 8'd1, 2, 2, 4'h7);
        run_until_drained(60, "drop");
        checks++;
        if (out_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL drop_out_count: got %0d beats, expected 2", out_q.size());
        end
        for (int b = 0; b < 2 && b < out_q.size(); b++) begin
            got = {out_q[b].data, out_q[b].keep, out_q[b].last, out_q[b].user};
            exp = {beat_data(1, 8'd1, 2, b), (b == 1) ? 4'h7 : 4'hF, b == 1, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL drop_fwd_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        checks++;
        if (drop_count !== 16'd1 || pkt_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL drop_counters: got drop %0d pkt %0d, expected 1 1", drop_count, pkt_count);
        end
    endtask

    task automatic test_single_beat();
        logic [37:0] got;
        logic [37:0] exp;
        apply_reset();
        push_pkt(0, 8'd3,   1, 1, 4'h1);
        push_pkt(0, 8'd1,   1, 2, 4'h1);
        push_pkt(0, 8'hFF,  1, 3, 4'h2);
        push_pkt(0, 8'd2,   1, 4, 4'h8);
        run_until_drained(40, "single_beat");
        checks++;
        if (out_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL single_beat_count: got %0d beats, expected 2", out_q.size());
        end
        if (out_q.size() == 2) begin
            got = {out_q[0].data, out_q[0].keep, out_q[0].last, out_q[0].user};
            exp = {beat_data(0, 8'd1, 2, 0), 4'h1, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL single_beat_first: got %h, expected %h", got, exp);
            end
            got = {out_q[1].data, out_q[1].keep, out_q[1].last, out_q[1].user};
            exp = {beat_data(0, 8'd2, 4, 0), 4'h8, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL single_beat_second: got %h, expected %h", got, exp);
            end
            checks++;
            if (out_q[1].cyc - out_q[0].cyc != 4) begin
                errors++;
                $display("[TB] FAIL single_beat_spacing: got %0d, expected 4", out_q[1].cyc - out_q[0].cyc);
            end
        end
        checks++;
        if (drop_count !== 16'd2 || pkt_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL single_beat_counters: got drop %0d pkt %0d, expected 2 2", drop_count, pkt_count);
        end
    endtask

    task automatic test_backpressure();
        int          step = -1;
        int          stalls = 0;
        logic        stalled_prev = 1'b0;
        logic [31:0] held = '0;
        logic [37:0] got;
        logic [37:0] exp;
        apply_reset();
        push_pkt(0, 8'd1, 4, 7, 4'hC);
        for (int n = 0; n < 60 && !(q0.size() == 0 && !m_axis_tvalid); n++) begin
            if (step < 0 && m_axis_tvalid) step = 0;
            m_axis_tready = !(step == 1 || step == 2);
            #1;
            if (stalled_prev) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== held) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got valid %b data %h, expected 1 %h", m_axis_tvalid, m_axis_tdata, held);
                end
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                checks++;
                if (s_axis_tready[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_tready: got %b, expected 0", s_axis_tready[0]);
                end
                held = m_axis_tdata;
                stalled_prev = 1'b1;
                stalls++;
            end else begin
                stalled_prev = 1'b0;
            end
            if (step >= 0) step++;
            tick();
        end
        m_axis_tready = 1'b1;
        run_until_drained(10, "backpressure");
        checks++;
        if (stalls != 2) begin
            errors++;
            $display("[TB] FAIL bp_stall_cycles: got %0d, expected 2", stalls);
        end
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d beats, expected 4", out_q.size());
        end
        for (int b = 0; b < 4 && b < out_q.size(); b++) begin
            got = {out_q[b].data, out_q[b].keep, out_q[b].last, out_q[b].user};
            exp = {beat_data(0, 8'd1, 7, b), (b == 3) ? 4'hC : 4'hF, b == 3, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL bp_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bp_pkt_count: got %0d, expected 1", pkt_count);
        end
    endtask

    // Relies on the previous scenario leaving pkt_count at 1 and lane 0 as
    // the last grant, so a cleared counter and lane-0 priority are visible.
    task automatic test_reset_mid_packet();
        int start = hs_total;
        int n = 0;
        m_axis_tready = 1'b1;
        out_q.delete();
        push_pkt(0, 8'd1, 4, 9, 4'hF);
        while (n < 10 && hs_total < start + 1) begin
            tick();
            n++;
        end
        checks++;
        if (hs_total < start + 1) begin
            errors++;
            $display("[TB] FAIL rst_mid_first_beat: got timeout, expected one handshake");
        end
        s_axis_aresetn = 1'b0;
        q0.delete();
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 39'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got %h, expected 0",
                     {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        end
        checks++;
        if ({pkt_count, drop_count, s_axis_tready[0], s_axis_tready[1]} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_counters: got pkt %0d drop %0d tready %b%b, expected 0 0 00",
                     pkt_count, drop_count, s_axis_tready[0], s_axis_tready[1]);
        end
        s_axis_aresetn = 1'b1;
        out_q.delete();
        push_pkt(1, 8'd1, 1, 1, 4'hF);
        push_pkt(0, 8'd1, 1, 2, 4'hF);
        run_until_drained(20, "reset_mid_packet");
        checks++;
        if (out_q.size() != 2 || out_q[0].user !== 1'b0 || out_q[1].user !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_priority: got %0d beats first lane %b, expected 2 beats first lane 0",
                     out_q.size(), (out_q.size() > 0) ? out_q[0].user : 1'bx);
        end
        checks++;
        if (pkt_count !== 16'd2 || drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_after: got pkt %0d drop %0d, expected 2 0", pkt_count, drop_count);
        end
    endtask

    // Counters are preset next to their limits before the final packets.
    task automatic test_counters();
        apply_reset();
        force dut.drop_count = 16'hFFFE;
        force dut.pkt_count  = 16'hFFFF;
        #1;
        release dut.drop_count;
        release dut.pkt_count;
        push_pkt(0, 8'd0, 1, 1, 4'hF);
        run_until_drained(10, "counters_drop1");
        checks++;
        if (drop_count !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL drop_reach_max: got %h, expected ffff", drop_count);
        end
        push_pkt(0, 8'd5, 2, 2, 4'hF);
        run_until_drained(10, "counters_drop2");
        checks++;
        if (drop_count !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL drop_saturate: got %h, expected ffff", drop_count);
        end
        push_pkt(0, 8'd1, 1, 3, 4'hF);
        run_until_drained(10, "counters_fwd");
        checks++;
        if (pkt_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL pkt_wrap: got %h, expected 0000", pkt_count);
        end
    endtask

    initial begin
        s_axis_aresetn = 1'b0;
        m_axis_tready  = 1'b0;
        drive_inputs();
        test_reset();
        test_single_lane();
        test_round_robin();
        test_drop();
        test_single_beat();
        test_backpressure();
        test_reset_mid_packet();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
